wb_master_seq: RTL

Wishbone initiator that turns a simple valid/ready command stream into single Wishbone classic read/write cycles on the FPGA register aperture, then returns each result on a valid/ready response stream. It sits on the fabric side in front of the FPGA IP slave decode. Test sequencers, boot-time register loaders and on-fabric controllers use it to reach the FPGA and QL-reserved registers without an AHB host. A bounded ACK timeout keeps a missing slave from hanging the initiator.

---
 rtl/wb_master_seq.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/wb_master_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_master_seq : valid/ready command stream to single Wishbone classic cycles
// Rev 1.0
// ---------------------------------------------------------------------------
module wb_master_seq #(
  parameter int                   ADDRWIDTH          = 17,
  parameter int                   DATAWIDTH          = 32,
  parameter int                   TIMEOUT_CYCLES     = 255,
  parameter int                   TIMEOUT_WIDTH      = 8,
  parameter logic [DATAWIDTH-1:0] TIMEOUT_READ_VALUE = 32'hBADFABAC,
  parameter int                   ERRCNT_WIDTH       = 8
) (
  input  logic                     WB_CLK,
  input  logic                     WB_RST,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic                     cmd_we_i,
  input  logic [ADDRWIDTH-1:0]     cmd_adr_i,
  input  logic [DATAWIDTH/8-1:0]   cmd_byte_stb_i,
  input  logic [DATAWIDTH-1:0]     cmd_dat_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [DATAWIDTH-1:0]     rsp_dat_o,
  output logic                     rsp_err_o,
  output logic [ADDRWIDTH-1:0]     WBm_ADR_o,
  output logic                     WBm_CYC_o,
  output logic                     WBm_STB_o,
  output logic                     WBm_WE_o,
  output logic                     WBm_RD_o,
  output logic [DATAWIDTH/8-1:0]   WBm_BYTE_STB_o,
  output logic [DATAWIDTH-1:0]     WBm_WR_DAT_o,
  input  logic [DATAWIDTH-1:0]     WBm_RD_DAT_i,
  input  logic                     WBm_ACK_i,
  output logic                     busy_o,
  output logic [ERRCNT_WIDTH-1:0]  err_cnt_o
);

  localparam logic [TIMEOUT_WIDTH-1:0] TMO_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                   state_q;
  logic                     cmd_ready_q;
  logic                     cyc_q;
  logic                     stb_q;
  logic                     we_q;
  logic                     rd_q;
  logic [ADDRWIDTH-1:0]     adr_q;
  logic [DATAWIDTH/8-1:0]   bstb_q;
  logic [DATAWIDTH-1:0]     wdat_q;
  logic                     rsp_valid_q;
  logic [DATAWIDTH-1:0]     rsp_dat_q;
  logic                     rsp_err_q;
  logic [TIMEOUT_WIDTH-1:0] tmo_q;
  logic [ERRCNT_WIDTH-1:0]  err_cnt_q;

  always_ff @(posedge WB_CLK) begin
    if (WB_RST) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      rd_q        <= 1'b0;
      adr_q       <= '0;
      bstb_q      <= '0;
      wdat_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      tmo_q       <= '0;
      err_cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid_i && cmd_ready_q) begin
            adr_q       <= cmd_adr_i;
            bstb_q      <= cmd_byte_stb_i;
            wdat_q      <= cmd_dat_i;
            we_q        <= cmd_we_i;
            rd_q        <= ~cmd_we_i;
            cyc_q       <= 1'b1;
            stb_q       <= 1'b1;
            tmo_q       <= '0;
            cmd_ready_q <= 1'b0;
            state_q     <= BUS;
          end
        end
        BUS: begin
          // ACK is checked first so it wins over a timeout in the same cycle
          if (WBm_ACK_i) begin
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            rd_q        <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_dat_q   <= we_q ? '0 : WBm_RD_DAT_i;
            state_q     <= RESP;
          end else if (tmo_q == TMO_LAST) begin
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            rd_q        <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_dat_q   <= we_q ? '0 : TIMEOUT_READ_VALUE;
            if (err_cnt_q != '1) begin
              err_cnt_q <= err_cnt_q + 1'b1;
            end
            state_q     <= RESP;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready_o    = cmd_ready_q;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_dat_o      = rsp_dat_q;
  assign rsp_err_o      = rsp_err_q;
  assign WBm_ADR_o      = adr_q;
  assign WBm_CYC_o      = cyc_q;
  assign WBm_STB_o      = stb_q;
  assign WBm_WE_o       = we_q;
  assign WBm_RD_o       = rd_q;
  assign WBm_BYTE_STB_o = bstb_q;
  assign WBm_WR_DAT_o   = wdat_q;
  assign busy_o         = (state_q != IDLE);
  assign err_cnt_o      = err_cnt_q;

endmodule
`default_nettype wire
